serial_adder_ctrl: RTL
======================

Name: serial_adder_ctrl

Overview:
- Bit-serial adder controller. Accepts two WIDTH-bit operands plus a carry-in over a valid/ready handshake.
- Sequences a single one-bit full-adder stage LSB-first over WIDTH cycles, then presents sum, carry-out and signed overflow on an output handshake.
- Trades latency for area wherever a ripple adder of full width is too costly.

Parameters:
WIDTH, 8, operand/sum width in bits; legal range 2..32
CNT_W, $clog2(WIDTH), bit-counter width; derived, not overridden

Ports:
clk  input  1  rising-edge clock
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  operands a, b, cin valid
in_ready  output  1  controller can accept operands
a  input  WIDTH  operand A
b  input  WIDTH  operand B
cin  input  1  carry-in for bit 0
out_valid  output  1  result valid
out_ready  input  1  consumer accepts result
sum  output  WIDTH  a + b + cin, modulo 2^WIDTH
cout  output  1  carry out of bit WIDTH-1
ovf  output  1  two's-complement overflow (carry into MSB XOR carry out of MSB)
busy  output  1  high in RUN or DONE

Behaviour:
- Reset (async assert, sync release): state=IDLE, in_ready=1, out_valid=0, busy=0, sum=0, cout=0, ovf=0. All shift, carry and counter registers are 0.
- FSM states: IDLE, RUN, DONE. Outputs are registered or decoded from state only; there is no combinational path from in_valid/out_ready to outputs.
- IDLE:
  - in_ready=1.
  - On in_valid&in_ready at an edge: a_sh<=a, b_sh<=b, carry<=cin, cnt<=0, state<=RUN.
- RUN:
  - in_ready=0; in_valid and a/b/cin are ignored.
  - Each edge: s=a_sh[0]^b_sh[0]^carry and c=majority(a_sh[0],b_sh[0],carry).
  - sum_sh shifts right with s into the MSB. a_sh and b_sh shift right. carry<=c, cnt<=cnt+1.
  - On the edge where cnt==WIDTH-1: capture ovf<=carry^c (carry into MSB XOR carry out), cout<=c, state<=DONE.
  - RUN lasts exactly WIDTH cycles.
- DONE:
  - out_valid=1; sum, cout and ovf are held stable.
  - On out_valid&out_ready: state<=IDLE, out_valid deasserts next cycle.
  - While out_ready=0, stay in DONE indefinitely; outputs are held stable.
- Latency and throughput:
  - Operands accepted at edge t0 give out_valid high after edge t0+WIDTH.
  - If out_ready=1, the next accept is no earlier than edge t0+WIDTH+2, so minimum issue interval is WIDTH+2 cycles.
  - in_ready is high only in IDLE; there is no overlapped accept in DONE.
- Counter: cnt never exceeds WIDTH-1 and does not wrap. Counter and shift registers hold their values outside RUN.
- sum/cout/ovf keep the last result after the DONE handshake, until the next DONE.
- Reset during RUN or DONE aborts immediately. The partial result is discarded, all outputs return to reset values, and no out_valid pulse is produced.
- Arithmetic is unsigned modulo 2^WIDTH. cout is the unsigned overflow; ovf is the signed overflow. Both are computed in the same pass.

Decomposition:
- Shared package/header: FSM state encodings (IDLE=2'd0, RUN=2'd1, DONE=2'd2) and the WIDTH legal-range check constant.
- One natural sub-module, serial_add_bit: the combinational one-bit full-add (s, c from a_bit, b_bit, carry) plus the carry flop. It has load (cin) and enable inputs, and rst_n clears the carry.
- The FSM, counter and shift registers stay in serial_adder_ctrl.

Test Plan:
- WIDTH=8, a=0x5A, b=0x33, cin=0 -> out_valid exactly 8 cycles after the accept edge; sum=0x8D, cout=0, ovf=1.
- a=0xFF, b=0x01, cin=0 -> sum=0x00, cout=1, ovf=0. Then a=0x7F, b=0x00, cin=1 -> sum=0x80, cout=0, ovf=1.
- out_ready held low for 5 cycles in DONE -> out_valid stays 1, sum/cout/ovf stable, in_ready=0. out_ready=1 -> IDLE next cycle, in_ready=1.
- in_valid held high with changing a/b during RUN -> no effect on the result; second operand pair accepted only on the first IDLE cycle; back-to-back issue interval=10 cycles.
- rst_n asserted at RUN cycle 4 -> outputs immediately return to reset values, no out_valid pulse. After release, a=0x01, b=0x01, cin=1 -> sum=0x03, cout=0, ovf=0.
- Randomised 1000 operand sets at WIDTH=8 and WIDTH=16 -> sum/cout/ovf match the reference model {cout,sum}=a+b+cin, ovf=(a[MSB]==b[MSB])&&(sum[MSB]!=a[MSB]).

Source files
------------

// File: rtl/serial_adder_ctrl_pkg.sv
// Shared encodings and parameter range for the bit-serial adder controller.
package serial_adder_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    localparam int WIDTH_MIN = 2;
    localparam int WIDTH_MAX = 32;

    function automatic bit width_legal(int w);
        return (w >= WIDTH_MIN) && (w <= WIDTH_MAX);
    endfunction

endpackage

// File: rtl/serial_add_bit.sv
// One-bit full-add stage with its own carry flop; load seeds the carry with cin.
module serial_add_bit (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic cin,
    input  logic en,
    input  logic a_bit,
    input  logic b_bit,
    output logic s,
    output logic c,
    output logic carry
);

    // Full-add of the current bit pair against the stored carry.
    always_comb begin
        s = a_bit ^ b_bit ^ carry;
        c = (a_bit & b_bit) | (a_bit & carry) | (b_bit & carry);
    end

    // Carry flop: seeded on load, advanced on each enabled bit step.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)    carry <= 1'b0;
        else if (load) carry <= cin;
        else if (en)   carry <= c;
    end

endmodule

// File: rtl/serial_adder_ctrl.sv
// Bit-serial adder controller: LSB-first over WIDTH cycles, result on a handshake.
module serial_adder_ctrl
    import serial_adder_ctrl_pkg::*;
#(
    parameter  int WIDTH = 8,
    localparam int CNT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] sum,
    output logic             cout,
    output logic             ovf,
    output logic             busy
);

    if (!width_legal(WIDTH)) begin : g_width_chk
        $error("serial_adder_ctrl: WIDTH out of range");
    end

    state_t           state, state_nxt;
    logic [WIDTH-1:0] a_sh, b_sh;
    // Upper WIDTH-1 bits of the partial sum; the newest bit joins at the top
    // and the final bit completes the word straight into the sum register.
    logic [WIDTH-2:0] sum_sh;
    logic [WIDTH-1:0] sum_nxt;
    logic [CNT_W-1:0] cnt;
    logic             accept, step, last;
    logic             s_bit, c_bit, carry;

    assign accept  = (state == IDLE) && in_valid;
    assign step    = (state == RUN);
    assign last    = step && (cnt == CNT_W'(WIDTH - 1));
    assign sum_nxt = {s_bit, sum_sh};

    serial_add_bit u_bit (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (accept),
        .cin   (cin),
        .en    (step),
        .a_bit (a_sh[0]),
        .b_bit (b_sh[0]),
        .s     (s_bit),
        .c     (c_bit),
        .carry (carry)
    );

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nxt;
    end

    // Next state and state-decoded handshake outputs.
    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        case (state)
            IDLE: begin
                in_ready = 1'b1;
                busy     = 1'b0;
                if (in_valid) state_nxt = RUN;
            end
            RUN:  if (last) state_nxt = DONE;
            DONE: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Operand shifters, bit counter and the held result.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sh   <= '0;
            b_sh   <= '0;
            sum_sh <= '0;
            cnt    <= '0;
            sum    <= '0;
            cout   <= 1'b0;
            ovf    <= 1'b0;
        end else if (accept) begin
            a_sh <= a;
            b_sh <= b;
            cnt  <= '0;
        end else if (step) begin
            a_sh   <= a_sh >> 1;
            b_sh   <= b_sh >> 1;
            sum_sh <= sum_nxt[WIDTH-1:1];
            if (last) begin
                sum  <= sum_nxt;
                cout <= c_bit;
                ovf  <= carry ^ c_bit;
            end else begin
                cnt <= cnt + CNT_W'(1);
            end
        end
    end

endmodule
